block_spawn_scheduler: RTL and testbench
========================================

BLOCK_SPAWN_SCHEDULER -- requirements
Module: block_spawn_scheduler

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 16: number of platform slots in the block store.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 400: playfield width in pixels.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 40: platform width in pixels. COLS = SCREEN_WIDTH/BLOCK_WIDTH.
REQ-004 SHALL have parameter SPAWN_GAP, default 50: vertical pixel spacing between consecutive spawned platforms.
REQ-005 SHALL have parameter SEED, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port view_valid, input, 1: the view manager offers a new view.
REQ-009 SHALL have port view_ready, output, 1: the scheduler accepts a view (IDLE only).
REQ-010 SHALL have port min_y, input, 32: unsigned bottom of the new view, sampled on handshake.
REQ-011 SHALL have port rd_idx, output, clog2(NUM_BLOCKS): slot index presented to the block store.
REQ-012 SHALL have ports rd_y (input, 32) and rd_active (input, 1): combinational store data for rd_idx, valid in the same cycle.
REQ-013 SHALL have port wr_en, output, 1: one-cycle write strobe to the block store.
REQ-014 SHALL have ports wr_idx (output, clog2(NUM_BLOCKS)), wr_x (output, 32), wr_y (output, 32) and wr_active (output, 1): write payload.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at the end of each scan.
REQ-016 SHALL have port respawn_count, output, clog2(NUM_BLOCKS)+1: number of slots rewritten in the last scan, held until the next scan ends.
REQ-017 SHALL have port overflow, output, 1: sticky flag, set when spawn height saturates.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, SCAN and DONE.
REQ-019 INIT SHALL write slot i (i = 0..NUM_BLOCKS-1) in consecutive cycles, one per cycle, with wr_y = i*SPAWN_GAP, wr_active = 1 and wr_x from REQ-024. It SHALL then load top_y = (NUM_BLOCKS-1)*SPAWN_GAP and enter IDLE.
REQ-020 In IDLE: view_ready = 1. On view_valid && view_ready, SHALL latch min_y, set idx = 0, clear the running count and enter SCAN. view_ready SHALL be 0 in every other state, and view_valid SHALL then be ignored.
REQ-021 In each SCAN cycle: rd_idx = idx. If !rd_active or rd_y < latched min_y (unsigned), SHALL assert wr_en with wr_idx = idx, wr_y = top_y + SPAWN_GAP, wr_active = 1 and wr_x per REQ-024, and SHALL then update top_y to wr_y and increment the count. Otherwise wr_en = 0.
REQ-022 idx SHALL increment every SCAN cycle. After the idx = NUM_BLOCKS-1 cycle the FSM SHALL enter DONE, so SCAN lasts exactly NUM_BLOCKS cycles.
REQ-023 DONE SHALL last one cycle: done = 1, respawn_count = running count, then IDLE. Handshake at cycle t gives done at cycle t+NUM_BLOCKS+1.
REQ-024 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, and SHALL advance only in cycles where wr_en = 1. wr_x = (lfsr[7:0] mod COLS) * BLOCK_WIDTH, using the pre-advance value, so 0 <= wr_x <= SCREEN_WIDTH-BLOCK_WIDTH.
REQ-025 If top_y + SPAWN_GAP exceeds 32'hFFFF_FFFF, wr_y SHALL be 32'hFFFF_FFFF, top_y SHALL hold there, and overflow SHALL be set until reset.
REQ-026 wr_en SHALL be 0 in IDLE and DONE. At most one write SHALL occur per cycle.

Reset
REQ-027 reset SHALL have priority over all inputs, including mid-INIT and mid-SCAN, aborting any scan without a done pulse.
REQ-028 While reset = 1: state = INIT with idx = 0, wr_en = 0, done = 0, view_ready = 0, respawn_count = 0, overflow = 0, lfsr = SEED (or 16'hACE1 if SEED = 0), top_y = 0.
REQ-029 The first INIT write SHALL occur in the first cycle after reset deasserts.

Verification (NUM_BLOCKS=16, SPAWN_GAP=50, BLOCK_WIDTH=40, SCREEN_WIDTH=400)
REQ-030 Release reset -> 16 consecutive writes, idx 0..15 with y 0,50,...,750, all wr_x multiples of 40 and <= 360; view_ready = 1 in the next cycle.
REQ-031 Store mirrors writes; handshake min_y = 120 -> slots with y 0, 50 and 100 rewritten with y 800, 850 and 900; done 17 cycles after handshake; respawn_count = 3.
REQ-032 Handshake min_y = 0 with all slots active -> no wr_en during 16-cycle SCAN; done pulse; respawn_count = 0; LFSR unchanged.
REQ-033 view_valid held high through SCAN -> ignored until IDLE, then accepted exactly once; a second min_y change during SCAN is not latched.
REQ-034 reset asserted at SCAN cycle 5 -> no done pulse; INIT rewrites y 0..750; the wr_x sequence matches the post-reset run of REQ-030.
REQ-035 Force top_y near the limit by driving slots with rd_active = 0 and SPAWN_GAP = 32'h8000_0000 -> second write has wr_y = 32'hFFFF_FFFF; overflow = 1 and stays set until reset.

Source files
------------

// File: rtl/block_spawn_scheduler.sv
// rtl/block_spawn_scheduler.sv - platform respawn scheduler for a scrolling playfield
// Seeds the block store, then refills slots that fell below the view above the highest platform.
module block_spawn_scheduler #(
  parameter int unsigned NUM_BLOCKS   = 16,
  parameter int unsigned SCREEN_WIDTH = 400,
  parameter int unsigned BLOCK_WIDTH  = 40,
  parameter int unsigned SPAWN_GAP    = 50,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int unsigned IW          = $clog2(NUM_BLOCKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          view_valid,
  output logic          view_ready,
  input  logic [31:0]   min_y,
  output logic [IW-1:0] rd_idx,
  input  logic [31:0]   rd_y,
  input  logic          rd_active,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic [31:0]   wr_x,
  output logic [31:0]   wr_y,
  output logic          wr_active,
  output logic          done,
  output logic [IW:0]   respawn_count,
  output logic          overflow
);

  localparam int unsigned   CW       = IW + 1;
  localparam int unsigned   COLS     = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {INIT, IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   min_y_q, min_y_d;
  logic [31:0]   top_y_q, top_y_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] respawn_count_q, respawn_count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic          last_idx;
  logic          hit;
  logic [32:0]   spawn_sum;
  logic          spawn_sat;
  logic [31:0]   spawn_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= INIT;
      idx_q           <= '0;
      min_y_q         <= '0;
      top_y_q         <= '0;
      count_q         <= '0;
      respawn_count_q <= '0;
      overflow_q      <= 1'b0;
      lfsr_q          <= SEED_EFF;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      min_y_q         <= min_y_d;
      top_y_q         <= top_y_d;
      count_q         <= count_d;
      respawn_count_q <= respawn_count_d;
      overflow_q      <= overflow_d;
      lfsr_q          <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (last_idx) state_d = IDLE;
      IDLE: if (view_valid) state_d = SCAN;
      SCAN: if (last_idx) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  assign last_idx  = (idx_q == LAST_IDX);
  assign spawn_sum = {1'b0, top_y_q} + 33'(SPAWN_GAP);
  assign spawn_sat = spawn_sum[32];
  assign spawn_y   = spawn_sat ? 32'hFFFF_FFFF : spawn_sum[31:0];
  assign hit       = !rd_active || (rd_y < min_y_q);

  // Strobes are masked by reset so nothing leaks out while the state register is held in INIT.
  always_comb begin
    view_ready = 1'b0;
    wr_en      = 1'b0;
    wr_y       = top_y_q;
    done       = 1'b0;
    if (!reset) begin
      case (state_q)
        INIT: wr_en = 1'b1;
        IDLE: view_ready = 1'b1;
        SCAN: begin
          wr_en = hit;
          wr_y  = spawn_y;
        end
        DONE: done = 1'b1;
      endcase
    end
  end

  assign rd_idx        = idx_q;
  assign wr_idx        = idx_q;
  assign wr_active     = 1'b1;
  assign wr_x          = (32'(lfsr_q[7:0]) % COLS) * BLOCK_WIDTH;
  assign respawn_count = respawn_count_q;
  assign overflow      = overflow_q;

  always_comb begin
    idx_d           = idx_q;
    min_y_d         = min_y_q;
    top_y_d         = top_y_q;
    count_d         = count_q;
    respawn_count_d = respawn_count_q;
    overflow_d      = overflow_q;
    lfsr_d          = lfsr_q;
    if (wr_en) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    case (state_q)
      INIT: begin
        // top_y doubles as the running INIT height and ends on the last slot's y.
        idx_d = last_idx ? '0 : idx_q + IW'(1);
        if (!last_idx) top_y_d = top_y_q + SPAWN_GAP;
      end
      IDLE: begin
        if (view_valid) begin
          min_y_d = min_y;
          idx_d   = '0;
          count_d = '0;
        end
      end
      SCAN: begin
        idx_d = last_idx ? '0 : idx_q + IW'(1);
        if (hit) begin
          top_y_d = spawn_y;
          count_d = count_q + CW'(1);
          if (spawn_sat) overflow_d = 1'b1;
        end
        if (last_idx) respawn_count_d = count_d;
      end
      DONE: ;
    endcase
  end

endmodule

// File: tb/tb_block_spawn_scheduler.sv
// tb/tb_block_spawn_scheduler.sv - directed scoreboard bench for block_spawn_scheduler
// Main instance uses defaults; a small second instance exercises spawn-height saturation.
module tb_block_spawn_scheduler;

  localparam int NB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        view_valid, view_ready;
  logic [31:0] min_y;
  logic [3:0]  rd_idx;
  logic [31:0] rd_y;
  logic        rd_active;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_x, wr_y;
  logic        wr_active, done, overflow;
  logic [4:0]  respawn_count;

  logic        view_valid2, view_ready2;
  logic        rd_idx2, wr_en2, wr_idx2, wr_active2, done2, overflow2;
  logic [31:0] wr_x2, wr_y2;
  logic [1:0]  respawn_count2;

  block_spawn_scheduler dut (
    .clk(clk), .reset(reset), .view_valid(view_valid), .view_ready(view_ready),
    .min_y(min_y), .rd_idx(rd_idx), .rd_y(rd_y), .rd_active(rd_active),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_active(wr_active),
    .done(done), .respawn_count(respawn_count), .overflow(overflow)
  );

  block_spawn_scheduler #(.NUM_BLOCKS(2), .SPAWN_GAP(32'h8000_0000)) dut2 (
    .clk(clk), .reset(reset), .view_valid(view_valid2), .view_ready(view_ready2),
    .min_y(32'd0), .rd_idx(rd_idx2), .rd_y(32'd0), .rd_active(1'b0),
    .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_x(wr_x2), .wr_y(wr_y2), .wr_active(wr_active2),
    .done(done2), .respawn_count(respawn_count2), .overflow(overflow2)
  );

  logic [31:0] st_y   [NB];
  logic        st_act [NB];
  assign rd_y      = st_y[rd_idx];
  assign rd_active = st_act[rd_idx];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        st_y[i]   <= 32'd0;
        st_act[i] <= 1'b0;
      end
    end else if (wr_en) begin
      st_y[wr_idx]   <= wr_y;
      st_act[wr_idx] <= wr_active;
    end
  end

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] x;
    logic [31:0] y;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] m_lfsr;
  logic [31:0] m_top;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          n_wr     = 0;

  logic        s_wr, s_done, s_ready, s_ovf, s_wr2, s_ovf2, s_ready2;
  logic [4:0]  s_resp;
  logic [31:0] s_wr2_y, s_x2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_x(input logic [15:0] l);
    return (32'(l[7:0]) % 32'd10) * 32'd40;
  endfunction

  // Taps of x^16+x^14+x^13+x^11+1 land on bits 0,2,3,5 of a right-shifting register.
  task automatic m_advance();
    m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
  endtask

  task automatic push_init();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back('{idx: 4'(i), x: m_x(m_lfsr), y: 32'(i * 50)});
      m_advance();
    end
    m_top = 32'd750;
  endtask

  task automatic push_scan(input logic [31:0] my);
    logic [31:0] y;
    for (int i = 0; i < NB; i++) begin
      if (!st_act[i] || st_y[i] < my) begin
        y = (m_top > 32'hFFFF_FFFF - 32'd50) ? 32'hFFFF_FFFF : m_top + 32'd50;
        exp_q.push_back('{idx: 4'(i), x: m_x(m_lfsr), y: y});
        m_top = y;
        m_advance();
      end
    end
  endtask

  task automatic mon();
    wr_t e;
    s_wr = wr_en;  s_done = done;  s_ready = view_ready;  s_resp = respawn_count;
    s_ovf = overflow;  s_wr2 = wr_en2;  s_wr2_y = wr_y2;  s_x2 = wr_x2;
    s_ovf2 = overflow2;  s_ready2 = view_ready2;
    if (wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) chk("unexpected_wr_en", 64'(wr_en), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_idx", 64'(wr_idx), 64'(e.idx));
        chk("wr_x", 64'(wr_x), 64'(e.x));
        chk("wr_y", 64'(wr_y), 64'(e.y));
        chk("wr_active", 64'(wr_active), 64'd1);
      end
    end
  endtask

  task automatic step();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_resp);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_done && k < 40);
    chk({tag, "_done_latency"}, 64'(k), 64'd17);
    chk({tag, "_respawn_count"}, 64'(s_resp), 64'(exp_resp));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic scan(input string tag, input logic [31:0] my, input int exp_resp);
    push_scan(my);
    view_valid = 1'b1;
    min_y      = my;
    step();
    chk({tag, "_handshake_ready"}, 64'(s_ready), 64'd1);
    view_valid = 1'b0;
    wait_done(tag, exp_resp);
    step();
    chk({tag, "_done_one_cycle"}, 64'(s_done), 64'd0);
  endtask

  task automatic run_init(input string tag);
    push_init();
    n_wr = 0;
    repeat (NB) step();
    chk({tag, "_write_count"}, 64'(n_wr), 64'd16);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    step();
    chk({tag, "_idle_ready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int seen_done;
    reset       = 1'b1;
    view_valid  = 1'b0;
    view_valid2 = 1'b0;
    min_y       = 32'd0;
    repeat (3) @(negedge clk);
    step();
    chk("reset_wr_en", 64'(s_wr), 64'd0);
    chk("reset_done", 64'(s_done), 64'd0);
    chk("reset_view_ready", 64'(s_ready), 64'd0);
    chk("reset_respawn_count", 64'(s_resp), 64'd0);
    chk("reset_overflow", 64'(s_ovf), 64'd0);

    reset = 1'b0;
    run_init("init");

    scan("scan_120", 32'd120, 3);
    scan("scan_0", 32'd0, 0);

    // view_valid stays high through the scan and min_y moves mid-scan.
    push_scan(32'd900);
    view_valid = 1'b1;
    min_y      = 32'd900;
    step();
    chk("held_handshake_ready", 64'(s_ready), 64'd1);
    k = 0;
    do begin
      if (k == 3) min_y = 32'hFFFF_FFFF;
      step();
      k++;
      if (k == 2) chk("held_ready_low_in_scan", 64'(s_ready), 64'd0);
    end while (!s_done && k < 40);
    chk("held_a_done_latency", 64'(k), 64'd17);
    chk("held_a_respawn_count", 64'(s_resp), 64'd15);
    chk("held_a_queue_empty", 64'(exp_q.size()), 64'd0);
    push_scan(32'hFFFF_FFFF);
    step();
    chk("held_b_handshake_ready", 64'(s_ready), 64'd1);
    view_valid = 1'b0;
    repeat (5) step();
    chk("respawn_count_held", 64'(s_resp), 64'd15);
    k = 5;
    do begin
      step();
      k++;
    end while (!s_done && k < 40);
    chk("held_b_done_latency", 64'(k), 64'd17);
    chk("held_b_respawn_count", 64'(s_resp), 64'd16);
    chk("held_b_queue_empty", 64'(exp_q.size()), 64'd0);
    step();

    // Reset lands on the fifth SCAN cycle and must abort without a done pulse.
    push_scan(32'hFFFF_FFFF);
    view_valid = 1'b1;
    min_y      = 32'hFFFF_FFFF;
    step();
    view_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    seen_done = 0;
    step();
    chk("abort_wr_en_in_reset", 64'(s_wr), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      if (s_done) seen_done = 1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    chk("abort_respawn_cleared", 64'(s_resp), 64'd0);
    reset = 1'b0;
    run_init("reinit");

    chk("sat_overflow_before", 64'(s_ovf2), 64'd0);
    view_valid2 = 1'b1;
    step();
    chk("sat_handshake_ready", 64'(s_ready2), 64'd1);
    view_valid2 = 1'b0;
    step();
    chk("sat_wr1_en", 64'(s_wr2), 64'd1);
    chk("sat_wr1_y", 64'(s_wr2_y), 64'hFFFF_FFFF);
    chk("sat_wr1_x_range", 64'((s_x2 % 32'd40 == 0) && (s_x2 <= 32'd360)), 64'd1);
    step();
    chk("sat_wr2_en", 64'(s_wr2), 64'd1);
    chk("sat_wr2_y", 64'(s_wr2_y), 64'hFFFF_FFFF);
    step();
    chk("sat_overflow_set", 64'(s_ovf2), 64'd1);
    step();
    view_valid2 = 1'b1;
    step();
    view_valid2 = 1'b0;
    repeat (4) step();
    chk("sat_overflow_sticky", 64'(s_ovf2), 64'd1);
    chk("main_overflow_clear", 64'(s_ovf), 64'd0);
    reset = 1'b1;
    step();
    step();
    chk("sat_overflow_reset", 64'(s_ovf2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
